// File: rtl/down_counter_parload.sv
// Loadable down-counter rate divider: emits a one-cycle tick every N enabled clocks,
// in periodic (auto-reload) or one-shot mode.
module down_counter_parload #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear_b,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             mode,
  output logic [WIDTH-1:0] q_out,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    if (load) begin
      // Load wins over enable: a pending terminal count is discarded, no tick.
      reload_d = d_in;
      count_d  = d_in;
      mode_d   = mode;
      state_d  = (d_in != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (enable) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (count_q == ONE) begin
              tick_d = 1'b1;
              if (mode_q) begin
                count_d = '0;
                state_d = HALT;
              end else begin
                count_d = reload_q;
              end
            end
          end
        end
        HALT:    count_d = '0;
        default: ;
      endcase
    end
  end

  assign q_out = count_q;
  assign tick  = tick_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == HALT);

endmodule

// File: tb/tb_down_counter_parload.sv
// Scoreboard bench for down_counter_parload: a behavioural model pushes the expected
// registered outputs per driven cycle; they are popped and compared after the edge.
module tb_down_counter_parload;

  localparam int WIDTH = 4;

  logic             clock;
  logic             clear_b;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] d_in;
  logic             mode;
  logic [WIDTH-1:0] q_out;
  logic             tick;
  logic             busy;
  logic             done;

  down_counter_parload #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .clear_b(clear_b),
    .enable (enable),
    .load   (load),
    .d_in   (d_in),
    .mode   (mode),
    .q_out  (q_out),
    .tick   (tick),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             tick;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int tick_seen = 0;

  // Behavioural reference state
  int m_cnt, m_rel, m_mode, m_st;  // m_st: 0 idle, 1 run, 2 halt
  int m_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_mode = 0; m_st = 0; m_tick = 0;
  endtask

  task automatic model_step(input bit en, input bit ld, input int d, input bit md);
    m_tick = 0;
    if (ld) begin
      m_rel = d; m_cnt = d; m_mode = md;
      m_st = (d != 0) ? 1 : 0;
    end else if (m_st == 1 && en) begin
      if (m_cnt > 1) m_cnt = m_cnt - 1;
      else begin
        m_tick = 1;
        if (m_mode != 0) begin m_cnt = 0; m_st = 2; end
        else m_cnt = m_rel;
      end
    end
  endtask

  task automatic cyc(input bit en, input bit ld, input int d, input bit md);
    exp_t e;
    @(negedge clock);
    enable = en; load = ld; d_in = d[WIDTH-1:0]; mode = md;
    model_step(en, ld, d, md);
    e.q = m_cnt[WIDTH-1:0]; e.tick = m_tick[0]; e.busy = (m_st == 1); e.done = (m_st == 2);
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("q_out", q_out, e.q);
      chk("tick",  tick,  e.tick);
      chk("busy",  busy,  e.busy);
      chk("done",  done,  e.done);
    end
    if (tick) tick_seen++;
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(en, 1'b0, 0, 1'b0);
  endtask

  initial begin
    clear_b = 1'b0; enable = 1'b0; load = 1'b0; d_in = '0; mode = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_q", q_out, 0);
    chk("rst_flags", {tick, busy, done}, 3'b000);
    @(negedge clock);
    clear_b = 1'b1;

    // Reset mid-count
    cyc(1, 1, 9, 0);
    run(4, 1);
    #2;
    clear_b = 1'b0;
    #1;
    chk("amid_q", q_out, 0);
    chk("amid_flags", {tick, busy, done}, 3'b000);
    model_reset();
    clear_b = 1'b1;
    tick_seen = 0;
    run(12, 1);
    chk("post_rst_ticks", tick_seen, 0);

    // Periodic divide-by-5
    cyc(1, 1, 5, 0);
    chk("load5_q", q_out, 5);
    tick_seen = 0;
    run(22, 1);
    chk("div5_ticks", tick_seen, 4);

    // One-shot N=3, then halt, then reload 2
    cyc(1, 1, 3, 1);
    run(3, 1);
    chk("oneshot_done", {q_out, tick, busy, done}, {4'd0, 3'b101});
    tick_seen = 0;
    run(10, 1);
    chk("halt_ticks", tick_seen, 0);
    cyc(1, 1, 2, 1);
    run(3, 1);

    // Enable gating N=4
    cyc(0, 1, 4, 0);
    tick_seen = 0;
    for (int i = 0; i < 16; i++) cyc(i[0] == 1'b0, 1'b0, 0, 1'b0);
    chk("gated_ticks", tick_seen, 2);

    // Load collision at count==1, then zero load
    cyc(1, 1, 3, 0);
    run(2, 1);
    chk("coll_pre", q_out, 1);
    cyc(1, 1, 7, 0);
    chk("coll_tick", tick, 0);
    chk("coll_q", q_out, 7);
    run(3, 1);
    cyc(1, 1, 0, 0);
    tick_seen = 0;
    run(5, 1);
    chk("zero_ticks", tick_seen, 0);

    // Boundaries N=15 and N=1
    cyc(1, 1, 15, 0);
    tick_seen = 0;
    run(32, 1);
    chk("div15_ticks", tick_seen, 2);
    cyc(1, 1, 1, 0);
    tick_seen = 0;
    run(6, 1);
    chk("div1_ticks", tick_seen, 6);
    cyc(1, 1, 1, 1);
    run(3, 1);

    // Random mix of loads, enables and modes
    for (int i = 0; i < 200; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
